fpro_mcs_bridge: RTL and testbench
==================================

Name: fpro_mcs_bridge

Overview:
- Upstream neighbour of the MMIO subsystem.
- Converts the soft-processor I/O bus (strobe/ready protocol, 32-bit byte address) into the single-cycle FPro bus that drives the MMIO subsystem and the video subsystem.
- Registers every request, decodes the bridge window, and returns read data with a fixed, bounded latency.

Parameters:
- BRG_BASE, 32'hC000_0000, base byte address of the bridge window; io_address[31:24] must equal BRG_BASE[31:24] for a hit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- io_addr_strobe  in  1  processor request qualifier
- io_read_strobe  in  1  read request
- io_write_strobe  in  1  write request
- io_byte_enable  in  4  write byte lanes
- io_address  in  32  byte address
- io_write_data  in  32  write data
- io_read_data  out  32  read data, valid while io_ready=1
- io_ready  out  1  one-cycle completion pulse
- mmio_cs / mmio_wr / mmio_rd  out  1 each  FPro MMIO controls
- mmio_addr  out  21  word address = io_address[22:2]
- mmio_wr_data  out  32  write data
- mmio_rd_data  in  32  combinational read data from the MMIO subsystem
- video_cs / video_wr / video_rd  out  1 each  FPro video controls
- video_addr  out  21  word address
- video_wr_data  out  32  write data
- video_rd_data  in  32  read data from the video subsystem

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0.
- Accept: in IDLE, a request is accepted when io_addr_strobe=1 and exactly one of io_read_strobe / io_write_strobe is 1.
  - On acceptance, latch address, write data, byte enable, and direction.
  - If both strobes are 1, or neither is, the request is dropped: no bus cycle and no io_ready.
- Decode of the latched address:
  - hit = addr[31:24]==BRG_BASE[31:24].
  - MMIO when hit and addr[23]=0; video when hit and addr[23]=1.
  - A miss produces no cs but still completes.
- States:
  - IDLE: wait for an accepted request. Next state is ACCESS.
  - ACCESS: exactly one cycle. Registered cs/rd/wr/addr/wr_data drive the selected port. On rd, capture the selected rd_data at the clock edge; on a miss, capture 32'h0. Next state is RESP.
  - RESP: io_ready=1 for one cycle. io_read_data holds the captured value (0 for writes). Next state is IDLE.
- Latency:
  - Strobe in cycle N, bus cycle in N+1, io_ready in N+2.
  - Back-to-back requests are accepted at the earliest in the cycle after RESP.
- Busy: strobes arriving outside IDLE are ignored. The processor contract is one outstanding request.
- Pulse width: cs/rd/wr are high only in ACCESS, never longer than one cycle per transaction.
- Write data: without the optional feature, byte enables are ignored and a 32-bit write is issued.
- Reset mid-transaction: returns to IDLE immediately, all outputs drop to 0, and no io_ready is produced.
- io_read_data is held until the next RESP; it does not need to be zeroed between responses.

Optional Feature:
- Macro: FPRO_BRIDGE_RMW_EN.
- When defined, partial writes (io_byte_enable not 4'hF and not 4'h0) run a read-modify-write:
  - RMW_RD: assert cs+rd and capture the old word.
  - RMW_WR: assert cs+wr with merged data. Lanes with enable=1 take io_write_data; the rest take the old word.
  - RESP: as above.
- RMW latency: io_ready in N+3.
- A byte_enable of 4'h0 completes with no bus cycle, io_ready at N+2.
- On a miss, the RMW also completes with no cs asserted.
- When the macro is not defined, RMW states are absent and all writes are full-word.

Test Plan:
- Read: io_address=32'hC000_0008, read strobe, mmio_rd_data=32'hDEAD_BEEF.
  - N+1: mmio_cs=1, mmio_rd=1, mmio_addr=21'h2.
  - N+2: io_ready=1, io_read_data=32'hDEAD_BEEF.
- Write: io_address=32'hC080_0010, data 32'h1234_5678.
  - N+1: video_cs=1, video_wr=1, video_addr=21'h4, video_wr_data=32'h1234_5678, mmio_cs=0.
  - N+2: io_ready=1.
- Miss: read at 32'h8000_0000 → no cs ever asserted; io_ready at N+2 with io_read_data=0.
- Busy: second strobe at N+1 → ignored; exactly one ACCESS cycle and one io_ready pulse.
- Reset: reset=0 asserted during ACCESS → all outputs 0 the same cycle; no io_ready after release.
- RMW (FPRO_BRIDGE_RMW_EN): old word 32'hAABB_CCDD, write 32'h1122_3344 with be=4'b0101.
  - Read cycle, then a write of 32'hAA22_CC44.
  - io_ready at N+3.

Source files
------------

// File: rtl/fpro_mcs_bridge.sv
// Soft-processor I/O bus to FPro bus bridge: registers each request, decodes the
// MMIO/video window and answers with fixed latency. Optional RMW: FPRO_BRIDGE_RMW_EN.
module fpro_mcs_bridge #(
    parameter logic [31:0] BRG_BASE = 32'hC000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        video_cs,
    output logic        video_wr,
    output logic        video_rd,
    output logic [20:0] video_addr,
    output logic [31:0] video_wr_data,
    input  logic [31:0] video_rd_data
);

`ifdef FPRO_BRIDGE_RMW_EN
    typedef enum logic [2:0] {IDLE, ACCESS, RESP, RMW_RD, RMW_WR} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t      state_reg;
    logic        sel_mmio_reg;
    logic        sel_video_reg;
    logic        is_wr_reg;
    logic        accept;
    logic        req_mmio;
    logic        req_video;
    logic [31:0] sel_rd_data;
    logic        unused_bits;

    assign accept    = io_addr_strobe & (io_read_strobe ^ io_write_strobe);
    assign req_mmio  = (io_address[31:24] == BRG_BASE[31:24]) & ~io_address[23];
    assign req_video = (io_address[31:24] == BRG_BASE[31:24]) &  io_address[23];

    // A miss has neither select set, so the captured word is zero.
    assign sel_rd_data = sel_mmio_reg  ? mmio_rd_data  :
                         sel_video_reg ? video_rd_data : 32'h0;

`ifdef FPRO_BRIDGE_RMW_EN
    logic [3:0]  be_reg;
    logic [31:0] merged_data;

    // Both write-data ports hold the latched processor word, so either can feed the merge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_data[8*gi +: 8] = be_reg[gi] ? mmio_wr_data[8*gi +: 8]
                                                   : sel_rd_data[8*gi +: 8];
    end
    assign unused_bits = ^io_address[1:0];
`else
    assign unused_bits = ^{io_address[1:0], io_byte_enable};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            sel_mmio_reg  <= 1'b0;
            sel_video_reg <= 1'b0;
            is_wr_reg     <= 1'b0;
            io_read_data  <= 32'h0;
            io_ready      <= 1'b0;
            mmio_cs       <= 1'b0;
            mmio_wr       <= 1'b0;
            mmio_rd       <= 1'b0;
            mmio_addr     <= 21'h0;
            mmio_wr_data  <= 32'h0;
            video_cs      <= 1'b0;
            video_wr      <= 1'b0;
            video_rd      <= 1'b0;
            video_addr    <= 21'h0;
            video_wr_data <= 32'h0;
`ifdef FPRO_BRIDGE_RMW_EN
            be_reg        <= 4'h0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sel_mmio_reg  <= req_mmio;
                        sel_video_reg <= req_video;
                        is_wr_reg     <= io_write_strobe;
                        mmio_addr     <= io_address[22:2];
                        video_addr    <= io_address[22:2];
                        mmio_wr_data  <= io_write_data;
                        video_wr_data <= io_write_data;
`ifdef FPRO_BRIDGE_RMW_EN
                        be_reg        <= io_byte_enable;
                        if (io_write_strobe && io_byte_enable != 4'hF && io_byte_enable != 4'h0) begin
                            state_reg <= RMW_RD;
                            mmio_cs   <= req_mmio;
                            mmio_rd   <= req_mmio;
                            video_cs  <= req_video;
                            video_rd  <= req_video;
                        end else if (io_write_strobe && io_byte_enable == 4'h0) begin
                            // Empty write: complete without touching the bus.
                            state_reg <= ACCESS;
                        end else
`endif
                        begin
                            state_reg <= ACCESS;
                            mmio_cs   <= req_mmio;
                            mmio_rd   <= req_mmio & io_read_strobe;
                            mmio_wr   <= req_mmio & io_write_strobe;
                            video_cs  <= req_video;
                            video_rd  <= req_video & io_read_strobe;
                            video_wr  <= req_video & io_write_strobe;
                        end
                    end
                end
                ACCESS: begin
                    mmio_cs      <= 1'b0;
                    mmio_rd      <= 1'b0;
                    mmio_wr      <= 1'b0;
                    video_cs     <= 1'b0;
                    video_rd     <= 1'b0;
                    video_wr     <= 1'b0;
                    io_read_data <= is_wr_reg ? 32'h0 : sel_rd_data;
                    io_ready     <= 1'b1;
                    state_reg    <= RESP;
                end
`ifdef FPRO_BRIDGE_RMW_EN
                RMW_RD: begin
                    mmio_rd       <= 1'b0;
                    video_rd      <= 1'b0;
                    mmio_wr       <= sel_mmio_reg;
                    video_wr      <= sel_video_reg;
                    mmio_wr_data  <= merged_data;
                    video_wr_data <= merged_data;
                    state_reg     <= RMW_WR;
                end
                RMW_WR: begin
                    mmio_cs      <= 1'b0;
                    mmio_wr      <= 1'b0;
                    video_cs     <= 1'b0;
                    video_wr     <= 1'b0;
                    io_read_data <= 32'h0;
                    io_ready     <= 1'b1;
                    state_reg    <= RESP;
                end
`endif
                RESP: begin
                    io_ready  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_mcs_bridge.sv
// Self-checking bench for fpro_mcs_bridge: vector table, random transactions against
// a spec-level model, and hand sequences for busy, reset and (optionally) RMW.
module tb_fpro_mcs_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic        io_ready;
    logic        mmio_cs, mmio_wr, mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data, mmio_rd_data;
    logic        video_cs, video_wr, video_rd;
    logic [20:0] video_addr;
    logic [31:0] video_wr_data, video_rd_data;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fpro_mcs_bridge dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .video_cs(video_cs), .video_wr(video_wr), .video_rd(video_rd),
        .video_addr(video_addr), .video_wr_data(video_wr_data), .video_rd_data(video_rd_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] vrd;
        logic [5:0]  exp_ctrl;   // {mcs, mrd, mwr, vcs, vrd, vwr} during the bus cycle
        logic [20:0] exp_waddr;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [5:0] ctrl();
        return {mmio_cs, mmio_rd, mmio_wr, video_cs, video_rd, video_wr};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: derived directly from the decode and completion rules.
    function automatic vec_t model(input logic [31:0] a, input logic rd, input logic wr,
                                   input logic [3:0] be, input logic [31:0] wd,
                                   input logic [31:0] mrd, input logic [31:0] vrd);
        vec_t v;
        bit ok, hit, is_m, is_v;
        ok   = (rd != wr);
        hit  = (a[31:24] == 8'hC0);
        is_m = ok && hit && !a[23];
        is_v = ok && hit && a[23];
        v.addr = a; v.rd = rd; v.wr = wr; v.be = be; v.wdata = wd; v.mrd = mrd; v.vrd = vrd;
        v.exp_ctrl  = {is_m, is_m && rd, is_m && wr, is_v, is_v && rd, is_v && wr};
        v.exp_waddr = a[22:2];
        v.exp_ready = ok;
        v.exp_rdata = (rd && is_m) ? mrd : (rd && is_v) ? vrd : 32'h0;
        return v;
    endfunction

    task automatic idle_inputs();
        io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        io_addr_strobe = 1; io_read_strobe = v.rd; io_write_strobe = v.wr;
        io_byte_enable = v.be; io_address = v.addr; io_write_data = v.wdata;
        mmio_rd_data = v.mrd; video_rd_data = v.vrd;
        @(posedge clk); #1;                                   // N+1
        idle_inputs();
        check("bus_ctrl", ctrl(), v.exp_ctrl);
        check("ready_early", io_ready, 1'b0);
        if (v.exp_ctrl[5]) check("mmio_addr", mmio_addr, v.exp_waddr);
        if (v.exp_ctrl[2]) check("video_addr", video_addr, v.exp_waddr);
        if (v.exp_ctrl[3]) check("mmio_wr_data", mmio_wr_data, v.wdata);
        if (v.exp_ctrl[0]) check("video_wr_data", video_wr_data, v.wdata);
        @(posedge clk); #1;                                   // N+2
        check("ready", io_ready, v.exp_ready);
        check("ctrl_after", ctrl(), 6'h0);
        if (v.exp_ready) check("read_data", io_read_data, v.exp_rdata);
        @(posedge clk); #1;                                   // N+3, idle again
        check("ready_pulse", io_ready, 1'b0);
        $display("[TB] txn %0d addr=%h rd=%0b wr=%0b ctrl=%b ready_exp=%0b rdata_exp=%h",
                 idx, v.addr, v.rd, v.wr, v.exp_ctrl, v.exp_ready, v.exp_rdata);
    endtask

    vec_t table_v[9];

    initial begin
        vec_t v;
        int cs_cnt, rdy_cnt;
        reset = 0;
        idle_inputs();
        io_byte_enable = 4'hF; io_address = 0; io_write_data = 0;
        mmio_rd_data = 0; video_rd_data = 0;

        //                 addr           rd wr be    wdata          mrd            vrd            ctrl       waddr      rdy rdata
        table_v[0] = '{32'hC000_0008, 1, 0, 4'hF, 32'h0,         32'hDEAD_BEEF, 32'h0BAD_F00D, 6'b110000, 21'h2,      1, 32'hDEAD_BEEF};
        table_v[1] = '{32'hC080_0010, 0, 1, 4'hF, 32'h1234_5678, 32'h1111_1111, 32'h2222_2222, 6'b000101, 21'h4,      1, 32'h0};
        table_v[2] = '{32'h8000_0000, 1, 0, 4'hF, 32'h0,         32'h3333_3333, 32'h4444_4444, 6'b000000, 21'h0,      1, 32'h0};
        table_v[3] = '{32'hC000_0000, 1, 1, 4'hF, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 6'b000000, 21'h0,      0, 32'h0};
        table_v[4] = '{32'hC000_0000, 0, 0, 4'hF, 32'h0,         32'h6666_6666, 32'h7777_7777, 6'b000000, 21'h0,      0, 32'h0};
        table_v[5] = '{32'hC0FF_FFFC, 1, 0, 4'hF, 32'h0,         32'h8888_8888, 32'hCAFE_F00D, 6'b000110, 21'h1F_FFFF, 1, 32'hCAFE_F00D};
        table_v[6] = '{32'hC07F_FFFC, 0, 1, 4'hF, 32'hA5A5_5A5A, 32'h9999_9999, 32'hAAAA_AAAA, 6'b101000, 21'h1F_FFFF, 1, 32'h0};
        table_v[7] = '{32'hC100_0000, 0, 1, 4'hF, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 6'b000000, 21'h0,      1, 32'h0};
        table_v[8] = '{32'hBF80_0000, 1, 0, 4'hF, 32'h0,         32'hEEEE_EEEE, 32'hFFFF_FFFF, 6'b000000, 21'h0,      1, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", ctrl(), 6'h0);
        check("reset_outs", |{io_ready, io_read_data, mmio_addr, mmio_wr_data, video_addr, video_wr_data}, 1'b0);
        reset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(table_v[i], i);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  dir;
            logic [3:0]  be;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:24] = 8'hC0;
            dir = 2'($urandom_range(0, 3));
`ifdef FPRO_BRIDGE_RMW_EN
            be = 4'hF;
`else
            be = 4'($urandom);
`endif
            v = model(a, dir[0], dir[1], be, $urandom, $urandom, $urandom);
            run_vec(v, 100 + i);
        end

        // Busy: a second strobe during ACCESS is ignored
        cs_cnt = 0; rdy_cnt = 0;
        io_addr_strobe = 1; io_read_strobe = 1; io_write_strobe = 0;
        io_address = 32'hC000_0020; mmio_rd_data = 32'h0102_0304;
        @(posedge clk); #1;
        io_read_strobe = 0; io_write_strobe = 1; io_address = 32'hC080_0040;
        for (int c = 0; c < 5; c++) begin
            cs_cnt  += int'(mmio_cs | video_cs);
            rdy_cnt += int'(io_ready);
            if (io_ready) check("busy_rdata", io_read_data, 32'h0102_0304);
            @(posedge clk); #1;
            idle_inputs();
        end
        check("busy_cs_cycles", cs_cnt, 1);
        check("busy_ready_pulses", rdy_cnt, 1);
        check("busy_no_video", video_cs, 1'b0);
        $display("[TB] txn busy cs_cycles=%0d ready_pulses=%0d", cs_cnt, rdy_cnt);

        // Reset asserted during ACCESS
        io_addr_strobe = 1; io_read_strobe = 1; io_address = 32'hC000_0030;
        @(posedge clk); #1;
        idle_inputs();
        check("pre_reset_access", mmio_cs, 1'b1);
        reset = 0;
        #1;
        check("midreset_ctrl", ctrl(), 6'h0);
        check("midreset_outs", |{io_ready, io_read_data, mmio_addr, mmio_wr_data, video_addr, video_wr_data}, 1'b0);
        @(posedge clk); #1;
        reset = 1;
        rdy_cnt = 0; cs_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            rdy_cnt += int'(io_ready);
            cs_cnt  += int'(mmio_cs | video_cs);
        end
        check("postreset_no_ready", rdy_cnt, 0);
        check("postreset_no_cs", cs_cnt, 0);
        $display("[TB] txn reset_mid_access ready_after=%0d", rdy_cnt);

`ifdef FPRO_BRIDGE_RMW_EN
        // Partial write: read-modify-write
        io_addr_strobe = 1; io_write_strobe = 1; io_byte_enable = 4'b0101;
        io_address = 32'hC000_0004; io_write_data = 32'h1122_3344; mmio_rd_data = 32'hAABB_CCDD;
        @(posedge clk); #1;
        idle_inputs(); io_byte_enable = 4'hF;
        check("rmw_rd_ctrl", ctrl(), 6'b110000);
        @(posedge clk); #1;
        check("rmw_wr_ctrl", ctrl(), 6'b101000);
        check("rmw_merged", mmio_wr_data, 32'hAA22_CC44);
        check("rmw_ready_n2", io_ready, 1'b0);
        @(posedge clk); #1;
        check("rmw_ready_n3", io_ready, 1'b1);
        check("rmw_ctrl_off", ctrl(), 6'h0);
        @(posedge clk); #1;
        $display("[TB] txn rmw merged=%h", 32'hAA22_CC44);
        // Empty byte enable: no bus cycle, ready at N+2
        io_addr_strobe = 1; io_write_strobe = 1; io_byte_enable = 4'h0; io_address = 32'hC000_0004;
        @(posedge clk); #1;
        idle_inputs(); io_byte_enable = 4'hF;
        check("be0_no_cs", ctrl(), 6'h0);
        @(posedge clk); #1;
        check("be0_ready", io_ready, 1'b1);
        @(posedge clk); #1;
        $display("[TB] txn be0 write");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
